// File: rtl/huff_decoder.sv
// huff_decoder -- receive end of the huff_encoder link.
//
// Purpose:
//   Loads a 3-entry Huffman code table from the encoder's word stream.
//   Each entry arrives as a char word followed by a code word.
//   It then decodes a serial, MSB-first code bitstream.
//   One 5-bit character is emitted for each matched codeword.
//
// Ports:
//   clk     in   1   clock
//   reset   in   1   synchronous, active-high reset
//   io_in   in  12   [11] table_strobe, [10] bit_valid, [9] bit_data,
//                    [8:0] table word
//                      char word: [8] done (ignored), [7:5]=3'b011, [4:0] char
//                      code word: [8] done (ignored), [7:6]=2'b00,
//                                 [5:3] mask, [2:0] value
//   io_out  out 12   [4:0] char_out, [5] char_valid, [6] error,
//                    [7] table_loaded, [11:8] emitted-character count
//
// Configuration:
//   HUFF_DEC_COUNT_EN -- when defined, io_out[11:8] is a wrapping 4-bit
//   count of emitted characters. It is cleared by reset and by a table
//   reload. When undefined, io_out[11:8] is tied to 0.

module huff_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] io_in,
    output logic [11:0] io_out
);
    localparam int MAX_CHAR_COUNT = 3;
    localparam int CODE_WIDTH     = 3;

    typedef enum logic [1:0] {LOAD_CHAR, LOAD_CODE, DECODE} state_t;

    logic       tableStrobe;
    logic       bitValid;
    logic       bitData;
    logic [7:0] tableBits;
    logic       unusedDoneBit;
    logic       isCharWord;
    logic       isCodeWord;

    state_t                                    state_q, state_d;
    logic [1:0]                                entry_q, entry_d;
    logic [MAX_CHAR_COUNT-1:0][4:0]            char_q, char_d;
    logic [MAX_CHAR_COUNT-1:0][CODE_WIDTH-1:0] mask_q, mask_d;
    logic [MAX_CHAR_COUNT-1:0][CODE_WIDTH-1:0] value_q, value_d;
    logic [MAX_CHAR_COUNT-1:0]                 valid_q, valid_d;
    logic [1:0]                                acc_q, acc_d;
    logic [1:0]                                accLen_q, accLen_d;
    logic [4:0]                                charOut_q, charOut_d;
    logic                                      charValid_q, charValid_d;
    logic                                      error_q, error_d;
    logic                                      loaded_q, loaded_d;

    logic [CODE_WIDTH-1:0]          nacc;
    logic [1:0]                     nlen;
    logic [MAX_CHAR_COUNT-1:0][1:0] codeLen;
    logic                           hit;
    logic [1:0]                     hitIdx;
    logic [3:0]                     count;

    function automatic logic maskOk(input logic [CODE_WIDTH-1:0] m);
        return (m == 3'b001) || (m == 3'b011) || (m == 3'b111);
    endfunction

    assign tableStrobe   = io_in[11];
    assign bitValid      = io_in[10];
    assign bitData       = io_in[9];
    assign unusedDoneBit = io_in[8];
    assign tableBits     = io_in[7:0];
    assign isCharWord    = (tableBits[7:5] == 3'b011);
    assign isCodeWord    = (tableBits[7:6] == 2'b00);

    // Only the low two accumulated bits are stored. A third bit either
    // completes a match or raises an error, so it is never kept.
    assign nacc = {acc_q, bitData};
    assign nlen = accLen_q + 2'd1;

    // Code length is the popcount of a (contiguous, LSB-aligned) mask.
    always_comb begin
        for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
            codeLen[i] = {1'b0, mask_q[i][0]} + {1'b0, mask_q[i][1]}
                       + {1'b0, mask_q[i][2]};
        end
    end

    // The loop runs from the highest index down, so the lowest matching
    // entry is the one that sticks.
    always_comb begin
        hit    = 1'b0;
        hitIdx = 2'd0;
        for (int i = MAX_CHAR_COUNT - 1; i >= 0; i--) begin
            if (valid_q[i] && (nlen == codeLen[i]) &&
                ((nacc & mask_q[i]) == value_q[i])) begin
                hit    = 1'b1;
                hitIdx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        char_d      = char_q;
        mask_d      = mask_q;
        value_d     = value_q;
        valid_d     = valid_q;
        acc_d       = acc_q;
        accLen_d    = accLen_q;
        charOut_d   = charOut_q;
        charValid_d = 1'b0;
        error_d     = 1'b0;
        loaded_d    = loaded_q;

        case (state_q)
            LOAD_CHAR: begin
                if (tableStrobe) begin
                    if (isCharWord) begin
                        char_d[entry_q] = tableBits[4:0];
                        state_d         = LOAD_CODE;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            LOAD_CODE: begin
                if (tableStrobe) begin
                    if (isCodeWord) begin
                        mask_d[entry_q]  = tableBits[5:3];
                        value_d[entry_q] = tableBits[2:0];
                        valid_d[entry_q] = maskOk(tableBits[5:3]);
                        if (entry_q == 2'(MAX_CHAR_COUNT - 1)) begin
                            // The entry index is unused while decoding.
                            entry_d  = 2'd0;
                            loaded_d = 1'b1;
                            state_d  = DECODE;
                        end else begin
                            entry_d = entry_q + 2'd1;
                            state_d = LOAD_CHAR;
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            DECODE: begin
                // A strobe restarts the load and takes priority over any
                // bit in the same cycle. The word is treated as entry 0's
                // char word.
                if (tableStrobe) begin
                    char_d   = '0;
                    mask_d   = '0;
                    value_d  = '0;
                    valid_d  = '0;
                    loaded_d = 1'b0;
                    acc_d    = 2'd0;
                    accLen_d = 2'd0;
                    entry_d  = 2'd0;
                    if (isCharWord) begin
                        char_d[0] = tableBits[4:0];
                        state_d   = LOAD_CODE;
                    end else begin
                        error_d = 1'b1;
                        state_d = LOAD_CHAR;
                    end
                end else if (bitValid) begin
                    if (hit) begin
                        charOut_d   = char_q[hitIdx];
                        charValid_d = 1'b1;
                        acc_d       = 2'd0;
                        accLen_d    = 2'd0;
                    end else if (nlen == 2'(CODE_WIDTH)) begin
                        error_d  = 1'b1;
                        acc_d    = 2'd0;
                        accLen_d = 2'd0;
                    end else begin
                        acc_d    = nacc[1:0];
                        accLen_d = nlen;
                    end
                end
            end
            default: state_d = LOAD_CHAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD_CHAR;
            entry_q     <= 2'd0;
            char_q      <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            valid_q     <= '0;
            acc_q       <= 2'd0;
            accLen_q    <= 2'd0;
            charOut_q   <= 5'd0;
            charValid_q <= 1'b0;
            error_q     <= 1'b0;
            loaded_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            char_q      <= char_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            acc_q       <= acc_d;
            accLen_q    <= accLen_d;
            charOut_q   <= charOut_d;
            charValid_q <= charValid_d;
            error_q     <= error_d;
            loaded_q    <= loaded_d;
        end
    end

`ifdef HUFF_DEC_COUNT_EN
    logic       reload;
    logic [3:0] count_q;

    assign reload = (state_q == DECODE) && tableStrobe;

    // The count steps together with the char_valid pulse and wraps 15->0.
    always_ff @(posedge clk) begin
        if (reset || reload) begin
            count_q <= 4'd0;
        end else if (charValid_d) begin
            count_q <= count_q + 4'd1;
        end
    end

    assign count = count_q;
`else
    assign count = 4'd0;
`endif

    assign io_out = {count, loaded_q, error_q, charValid_q, charOut_q};

endmodule
